// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive front end.
package uart_rx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    localparam int RX_DATA_BITS = 8;

    function automatic int baud_cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic single-bit two-flop synchronizer for asynchronous tile inputs.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_frontend.sv
// 8N1 UART receiver presenting bytes to the user core over valid/ready,
// with framing-error pulse and sticky overrun flag.
module uart_rx_frontend
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_valid,
    input  logic       data_ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int BW  = baud_cnt_w(CLKS_PER_BIT);
    localparam int BCW = $clog2(RX_DATA_BITS);
    localparam int H   = CLKS_PER_BIT / 2;

    localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0]  HALF_LAST = BW'(H - 1);
    localparam logic [BCW-1:0] BIT_LAST  = BCW'(RX_DATA_BITS - 1);

    logic rx_s;

    sync_2ff #(.RESET_VAL(1'b1)) u_rx_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

    rx_state_t state, next_state;

    logic [BW-1:0]           baud_cnt;
    logic [BCW-1:0]          bit_cnt;
    logic [RX_DATA_BITS-1:0] shift_reg;
    logic                    break_wait;
    logic                    stop_evt;
    logic                    stop_ok;

    logic baud_clr;
    logic baud_inc;
    logic bit_shift;
    logic stop_take;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        baud_clr   = 1'b0;
        baud_inc   = 1'b0;
        bit_shift  = 1'b0;
        stop_take  = 1'b0;
        if (!ena) begin
            next_state = IDLE;
            baud_clr   = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (!rx_s && !break_wait) begin
                        next_state = START;
                        baud_clr   = 1'b1;
                    end
                end
                START: begin
                    if (baud_cnt == HALF_LAST) begin
                        baud_clr   = 1'b1;
                        next_state = rx_s ? IDLE : DATA;
                    end else begin
                        baud_inc = 1'b1;
                    end
                end
                DATA: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_clr  = 1'b1;
                        bit_shift = 1'b1;
                        if (bit_cnt == BIT_LAST) begin
                            next_state = STOP;
                        end
                    end else begin
                        baud_inc = 1'b1;
                    end
                end
                STOP: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_clr   = 1'b1;
                        stop_take  = 1'b1;
                        next_state = IDLE;
                    end else begin
                        baud_inc = 1'b1;
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    // The stop-bit verdict is registered first, so the byte is delivered one
    // cycle after the stop sample; the shift register is quiet by then.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            break_wait <= 1'b0;
            stop_evt   <= 1'b0;
            stop_ok    <= 1'b0;
        end else begin
            if (baud_clr) begin
                baud_cnt <= '0;
            end else if (baud_inc) begin
                baud_cnt <= baud_cnt + 1'b1;
            end

            if (state != DATA || !ena) begin
                bit_cnt <= '0;
            end else if (bit_shift) begin
                bit_cnt <= bit_cnt + 1'b1;
            end

            if (bit_shift) begin
                shift_reg <= {rx_s, shift_reg[RX_DATA_BITS-1:1]};
            end

            if (stop_take && !rx_s) begin
                break_wait <= 1'b1;
            end else if (ena && state == IDLE && rx_s) begin
                break_wait <= 1'b0;
            end

            stop_evt <= stop_take;
            if (stop_take) begin
                stop_ok <= rx_s;
            end
        end
    end

    logic accept;
    logic load;

    assign accept = data_valid && data_ready;
    assign load   = stop_evt && stop_ok;

    // Holding register: a same-cycle accept frees the slot for the new byte.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            frame_err <= stop_evt && !stop_ok;
            if (load) begin
                if (!data_valid || accept) begin
                    data_out   <= shift_reg;
                    data_valid <= 1'b1;
                    overrun    <= 1'b0;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (accept) begin
                data_valid <= 1'b0;
                overrun    <= 1'b0;
            end
        end
    end

endmodule
